// File: rtl/sumdiff_ctrl.sv
// sumdiff_ctrl: arbitrates a sum requester (A+B) and a difference requester
// (A-B) onto one shared combinational adder, returning tagged, registered
// results on a single response channel.
// Difference is formed as A + (~B + 1); the negation is done here.
// Optional build macro: SUMDIFF_SAT_EN -- saturate rsp_result on overflow.
// Without it rsp_result is the wrapped two's-complement adder output.

module sumdiff_ctrl #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             sum_valid,
    output logic             sum_ready,
    input  logic [WIDTH-1:0] sum_a,
    input  logic [WIDTH-1:0] sum_b,

    input  logic             dif_valid,
    output logic             dif_ready,
    input  logic [WIDTH-1:0] dif_a,
    input  logic [WIDTH-1:0] dif_b,

    output logic [WIDTH-1:0] add_inA,
    output logic [WIDTH-1:0] add_inB,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_of,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_of,
    output logic             rsp_op,

    output logic             busy
);

    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
`ifdef SUMDIFF_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG    = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             ptr_dif;     // 0: sum requester has priority, 1: difference
    logic [CNT_W-1:0] settle_cnt;
    logic             op_q;        // 0 = sum, 1 = difference
    logic             op_b_msb_q;  // sign of the original (un-negated) subtrahend

    logic             grant_sum;
    logic             grant_dif;
    logic [WIDTH-1:0] neg_dif_b;
    logic             of_c;
    logic [WIDTH-1:0] result_c;

    // Round-robin grant; a lone requester always wins.
    always_comb begin
        grant_sum = 1'b0;
        grant_dif = 1'b0;
        if (sum_valid && (!dif_valid || !ptr_dif)) begin
            grant_sum = 1'b1;
        end else if (dif_valid) begin
            grant_dif = 1'b1;
        end
    end

    // Ready only in IDLE and never during the reset cycle.
    assign sum_ready = (state == IDLE) && !rst && grant_sum;
    assign dif_ready = (state == IDLE) && !rst && grant_dif;

    // Two's-complement negation of the subtrahend (wraps for the most negative value).
    assign neg_dif_b = (~dif_b) + ONE;

    // Overflow and (optionally saturated) result from the current adder output.
    always_comb begin
        of_c     = add_of;
        result_c = add_sum;
        if (op_q) begin
            of_c = (add_inA[MSB] != op_b_msb_q) && (add_sum[MSB] != add_inA[MSB]);
        end
`ifdef SUMDIFF_SAT_EN
        if (of_c) begin
            result_c = add_inA[MSB] ? MAX_NEG : MAX_POS;
        end
`endif
    end

    // Sequencer: accept, hold adder inputs for SETTLE cycles, present result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr_dif    <= 1'b0;
            settle_cnt <= '0;
            op_q       <= 1'b0;
            op_b_msb_q <= 1'b0;
            add_inA    <= '0;
            add_inB    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_of     <= 1'b0;
            rsp_op     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dif_ready) begin
                        add_inA    <= dif_a;
                        add_inB    <= neg_dif_b;
                        op_q       <= 1'b1;
                        op_b_msb_q <= dif_b[MSB];
                        ptr_dif    <= 1'b0;
                        settle_cnt <= CNT_ONE;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end else if (sum_ready) begin
                        add_inA    <= sum_a;
                        add_inB    <= sum_b;
                        op_q       <= 1'b0;
                        op_b_msb_q <= sum_b[MSB];
                        ptr_dif    <= 1'b1;
                        settle_cnt <= CNT_ONE;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (settle_cnt >= SETTLE_CNT) begin
                        rsp_result <= result_c;
                        rsp_of     <= of_c;
                        rsp_op     <= op_q;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumdiff_ctrl.sv
// Directed self-checking bench for sumdiff_ctrl with a behavioural 6-bit adder.
module tb_sumdiff_ctrl;

    localparam int unsigned WIDTH  = 6;
    localparam int unsigned SETTLE = 3;
    localparam int          BUDGET = 50;

`ifdef SUMDIFF_SAT_EN
    localparam logic [5:0] EXP_31P1 = 6'd31;
    localparam logic [5:0] EXP_0M32 = 6'd31;
    localparam logic [5:0] EXP_M32M1 = 6'd32;
`else
    localparam logic [5:0] EXP_31P1 = 6'd32;
    localparam logic [5:0] EXP_0M32 = 6'd32;
    localparam logic [5:0] EXP_M32M1 = 6'd31;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             sum_valid, sum_ready, dif_valid, dif_ready;
    logic [WIDTH-1:0] sum_a, sum_b, dif_a, dif_b;
    logic [WIDTH-1:0] add_inA, add_inB, add_sum;
    logic             add_of;
    logic             rsp_valid, rsp_ready, rsp_of, rsp_op, busy;
    logic [WIDTH-1:0] rsp_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference shared adder with signed-overflow flag.
    assign add_sum = add_inA + add_inB;
    assign add_of  = (add_inA[WIDTH-1] == add_inB[WIDTH-1]) && (add_sum[WIDTH-1] != add_inA[WIDTH-1]);

    sumdiff_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_a(sum_a), .sum_b(sum_b),
        .dif_valid(dif_valid), .dif_ready(dif_ready), .dif_a(dif_a), .dif_b(dif_b),
        .add_inA(add_inA), .add_inB(add_inB), .add_sum(add_sum), .add_of(add_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_of(rsp_of), .rsp_op(rsp_op), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // One isolated request with rsp_ready held high.
    task automatic run_op(input string tag, input logic op, input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] exp_inb, input logic [5:0] exp_res, input logic exp_of);
        int n;
        @(posedge clk); #1;
        if (!op) begin sum_valid = 1'b1; sum_a = a; sum_b = b; end
        else     begin dif_valid = 1'b1; dif_a = a; dif_b = b; end
        @(negedge clk);
        check_eq({tag, "_rdy"}, op ? dif_ready : sum_ready, 1);
        @(posedge clk); #1;
        check_eq({tag, "_rdy_pulse"}, {sum_ready, dif_ready}, 0);
        sum_valid = 1'b0; dif_valid = 1'b0;
        sum_a = ~a; sum_b = ~b; dif_a = ~a; dif_b = ~b;
        check_eq({tag, "_inA"}, add_inA, a);
        check_eq({tag, "_inB"}, add_inB, exp_inb);
        wait_rsp(n);
        check_eq({tag, "_lat"}, n, SETTLE);
        check_eq({tag, "_inB_hold"}, add_inB, exp_inb);
        check_eq({tag, "_res"}, rsp_result, exp_res);
        check_eq({tag, "_of"}, rsp_of, exp_of);
        check_eq({tag, "_op"}, rsp_op, op);
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, {rsp_valid, busy}, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; rsp_ready = 1'b1;
        sum_valid = 1'b1; sum_a = 6'd1;  sum_b = 6'd2;
        dif_valid = 1'b1; dif_a = 6'd10; dif_b = 6'd3;

        // Reset state, with both requesters already valid.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_rsp", {rsp_valid, rsp_of, rsp_op, rsp_result}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_add", {add_inA, add_inB}, 0);
        check_eq("rst_rdy", {sum_ready, dif_ready}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("arb_first", {sum_ready, dif_ready}, 2'b10);

        // Both valid continuously: alternate sum, dif, sum, dif.
        for (int i = 0; i < 4; i++) begin
            wait_rsp(n);
            check_eq("arb_timeout", n < BUDGET, 1);
            check_eq("arb_op", rsp_op, i % 2);
            check_eq("arb_res", rsp_result, (i % 2) ? 7 : 3);
            if (i == 3) begin sum_valid = 1'b0; dif_valid = 1'b0; end
            @(posedge clk); #1;
        end

        // Directed arithmetic, including overflow corners.
        run_op("sum15p8",  1'b0, 6'd15, 6'd8,  6'd8,  6'd23,    1'b0);
        run_op("dif15m8",  1'b1, 6'd15, 6'd8,  6'd56, 6'd7,     1'b0);
        run_op("sum31p1",  1'b0, 6'd31, 6'd1,  6'd1,  EXP_31P1, 1'b1);
        run_op("dif0m32",  1'b1, 6'd0,  6'd32, 6'd32, EXP_0M32, 1'b1);
        run_op("difm32m1", 1'b1, 6'd32, 6'd1,  6'd63, EXP_M32M1, 1'b1);
        run_op("summ1m1",  1'b0, 6'd63, 6'd63, 6'd63, 6'd62,    1'b0);

        // Response backpressure with both requesters valid.
        do_reset();
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        sum_valid = 1'b1; sum_a = 6'd5; sum_b = 6'd6;
        dif_valid = 1'b1; dif_a = 6'd9; dif_b = 6'd4;
        @(negedge clk);
        check_eq("bp_rdy", {sum_ready, dif_ready}, 2'b10);
        @(posedge clk); #1;
        wait_rsp(n);
        check_eq("bp_timeout", n < BUDGET, 1);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_hold", {rsp_valid, busy, sum_ready, dif_ready, rsp_op, rsp_of, rsp_result},
                     {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd11});
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release", {rsp_valid, busy, sum_ready, dif_ready}, 4'b0001);
        @(posedge clk); #1;
        check_eq("bp_accept", {busy, dif_ready}, 2'b10);
        sum_valid = 1'b0; dif_valid = 1'b0;
        wait_rsp(n);
        check_eq("bp_dif_res", {rsp_op, rsp_result}, {1'b1, 6'd5});
        @(posedge clk); #1;

        // Reset during EXEC discards the in-flight sum and restores sum priority.
        @(posedge clk); #1;
        sum_valid = 1'b1; sum_a = 6'd20; sum_b = 6'd20;
        @(posedge clk); #1;
        check_eq("rx_busy", busy, 1);
        sum_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sum_valid = 1'b1; sum_a = 6'd3; sum_b = 6'd4;
        dif_valid = 1'b1; dif_a = 6'd9; dif_b = 6'd1;
        @(negedge clk);
        check_eq("rx_rdy_in_rst", {sum_ready, dif_ready}, 0);
        @(posedge clk); #1;
        check_eq("rx_cleared", {rsp_valid, busy}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rx_ptr", {sum_ready, dif_ready}, 2'b10);
        @(posedge clk); #1;
        sum_valid = 1'b0; dif_valid = 1'b0;
        wait_rsp(n);
        check_eq("rx_lat", n, SETTLE);
        check_eq("rx_res", {rsp_op, rsp_of, rsp_result}, {1'b0, 1'b0, 6'd7});
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
